mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Control stage that sits directly upstream of the 2-input bus multiplexer.
- Arbitrates between two requesters with round-robin fairness.
- Drives the mux `sel` and `enable` inputs and holds the grant until the downstream consumer accepts the transfer.
- Acknowledges the winning requester on acceptance and counts completed transfers.
- Data never passes through this block; it only steers the mux.

Parameters:
- `cntBits`, 8, width of the completed-transfer counter.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `resetN`  in  1  asynchronous active-low reset.
- `req_0`  in  1  channel 0 requests a transfer; held high until `ack_0`.
- `req_1`  in  1  channel 1 requests a transfer; held high until `ack_1`.
- `outReady`  in  1  downstream consumer accepts the mux output this cycle.
- `sel`  out  1  mux select; 0 = channel 0, 1 = channel 1; registered.
- `enable`  out  1  mux enable; also serves as output-valid to downstream; registered.
- `ack_0`  out  1  combinational; high for the one cycle in which channel 0 data is accepted.
- `ack_1`  out  1  combinational; high for the one cycle in which channel 1 data is accepted.
- `xferCount`  out  `cntBits`  number of completed transfers, modulo 2^`cntBits`.

Behaviour:
- Clock and reset: single clock domain, port `clock`. Reset port `resetN` is asynchronous and active-low.
- Reset values (applied immediately when `resetN`=0, independent of clock):
  - state = IDLE
  - `sel`=0, `enable`=0, `xferCount`=0
  - internal `lastGrant`=1, so channel 0 wins the first contention
  - `ack_0`=`ack_1`=0 because `enable`=0
- State IDLE (`enable`=0):
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, go to BUSY with `sel` = that channel.
  - If both are high, go to BUSY with `sel` = not `lastGrant`.
  - Latency: request high at edge N gives `enable`=1 and valid `sel` after edge N+1 (1 cycle).
- State BUSY (`enable`=1, `sel` frozen):
  - Transfer condition = BUSY & `outReady`.
  - `ack_<sel>` = transfer; the other ack stays 0.
  - On the transfer edge:
    - `lastGrant` <= `sel`.
    - `xferCount` increments by 1, wrapping from all-ones to 0.
    - If the other channel's request is high, stay in BUSY and set `sel` to the other channel. This is a back-to-back handoff with no bubble.
    - Otherwise go to IDLE with `enable`=0.
  - The channel just served is never re-granted without passing through IDLE. This gives a mandatory one-cycle bubble and guarantees fairness.
- Abandoned request: if `req_<sel>` is 0 while in BUSY and `outReady`=0, go to IDLE on the next edge. No ack is issued, no count is taken, and `lastGrant` is unchanged.
- If `req_<sel>` is 0 and `outReady`=1 in the same cycle, the cycle counts as a transfer (ack issued). The requester protocol forbids this case.
- `outReady` in IDLE is ignored.
- Reset asserted mid-BUSY: `enable` drops immediately and no ack is produced. After `resetN` is released, arbitration restarts with channel 0 priority.
- `sel` changes only on clock edges and only in the cases above. The downstream mux output is therefore stable throughout each BUSY cycle.

Test Plan:
1. Reset, then `req_0`=1 only, `outReady`=1 from cycle 2:
   - `enable`=1 and `sel`=0 one cycle after the request.
   - `ack_0` pulses for one cycle, then IDLE.
   - `xferCount`=1.
2. `req_0`=`req_1`=1 held, `outReady`=1 continuously, both requesters re-asserting after each ack:
   - `sel` sequence 0,1,0,1… with no bubble between channels.
   - `xferCount` reaches 4 after 4 acks.
3. Only `req_1`=1 held for 3 transfers:
   - Pattern BUSY/IDLE/BUSY/IDLE with an `ack_1` every 2nd cycle.
   - `sel` stays 1.
4. Grant to channel 0, `outReady`=0 for 5 cycles, then 1:
   - `enable` and `sel`=0 stable for all 5 cycles with no ack.
   - `ack_0` appears in cycle 6.
5. BUSY with `sel`=1 and `outReady`=0, then `req_1` drops:
   - IDLE on the next edge, no ack, `xferCount` unchanged.
   - A following contention grants channel 0.
6. Set `cntBits`=2 and run 5 transfers: `xferCount` goes 1,2,3,0,1. Then assert `resetN`=0 mid-BUSY: `enable`, `sel` and `xferCount` become 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/mux2_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter_if
//   Groups the request/handshake signals between two requesters, the
//   2-input bus multiplexer and its downstream consumer, around the
//   mux2_rr_arbiter control stage.
//
//   Parameter:
//     cntBits   width of the completed-transfer counter
//
//   Signals:
//     req_0     channel 0 request, held high until ack_0
//     req_1     channel 1 request, held high until ack_1
//     outReady  downstream consumer accepts the mux output this cycle
//     sel       mux select (0 = channel 0, 1 = channel 1), registered
//     enable    mux enable / output-valid to downstream, registered
//     ack_0     one-cycle acknowledge to channel 0 on acceptance
//     ack_1     one-cycle acknowledge to channel 1 on acceptance
//     xferCount completed transfers, modulo 2^cntBits
//
//   Modports:
//     master    the arbiter side (drives sel/enable/acks/count)
//     slave     the requester / consumer side
// ---------------------------------------------------------------------------
interface mux2_rr_arbiter_if #(
  parameter int cntBits = 8
);

  logic               req_0;
  logic               req_1;
  logic               outReady;
  logic               sel;
  logic               enable;
  logic               ack_0;
  logic               ack_1;
  logic [cntBits-1:0] xferCount;

  modport master (
    input  req_0,
    input  req_1,
    input  outReady,
    output sel,
    output enable,
    output ack_0,
    output ack_1,
    output xferCount
  );

  modport slave (
    output req_0,
    output req_1,
    output outReady,
    input  sel,
    input  enable,
    input  ack_0,
    input  ack_1,
    input  xferCount
  );

endinterface : mux2_rr_arbiter_if

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//   Control stage sitting directly upstream of a 2-input bus multiplexer.
//   Arbitrates between two requesters with round-robin fairness, drives the
//   mux sel/enable, holds the grant until the downstream consumer accepts,
//   acknowledges the winner on acceptance and counts completed transfers.
//   No data passes through this block.
//
//   Parameter:
//     cntBits   width of the completed-transfer counter (default 8)
//
//   Ports:
//     clock     system clock, rising-edge
//     resetN    asynchronous active-low reset
//     bus       mux2_rr_arbiter_if.master (req_0/req_1/outReady in;
//               sel/enable/ack_0/ack_1/xferCount out)
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
  parameter int cntBits = 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  mux2_rr_arbiter_if.master     bus
);

  // Single-bit encoding: the state flop is itself the registered enable.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [cntBits-1:0] CNT_ZERO = '0;
  localparam logic [cntBits-1:0] CNT_ONE  = cntBits'(1);

  state_e             state_q;
  state_e             state_d;
  logic               sel_q;
  logic               sel_d;
  logic               last_grant_q;
  logic               last_grant_d;
  logic [cntBits-1:0] count_q;
  logic [cntBits-1:0] count_d;

  logic               busy_s;
  logic               xfer_s;
  logic               req_sel_s;
  logic               req_other_s;

  // Decode the request of the granted channel and of the other channel,
  // and the transfer condition (grant held and consumer accepting).
  always_comb begin
    busy_s      = (state_q == ST_BUSY);
    req_sel_s   = sel_q ? bus.req_1 : bus.req_0;
    req_other_s = sel_q ? bus.req_0 : bus.req_1;
    xfer_s      = busy_s && bus.outReady;
  end

  // Next-state logic for the grant FSM, select, round-robin pointer and count.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        // outReady is deliberately ignored here: nothing is granted yet.
        if (bus.req_0 && bus.req_1) begin
          // Contention: the channel not served last wins.
          state_d = ST_BUSY;
          sel_d   = ~last_grant_q;
        end else if (bus.req_0) begin
          state_d = ST_BUSY;
          sel_d   = 1'b0;
        end else if (bus.req_1) begin
          state_d = ST_BUSY;
          sel_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (xfer_s) begin
          last_grant_d = sel_q;
          count_d      = count_q + CNT_ONE;
          if (req_other_s) begin
            // Back-to-back handoff to the waiting channel, no bubble.
            state_d = ST_BUSY;
            sel_d   = ~sel_q;
          end else begin
            // The served channel must pass through IDLE before it can be
            // granted again, which keeps the arbitration fair.
            state_d = ST_IDLE;
          end
        end else if (!req_sel_s) begin
          // Requester withdrew before acceptance: release without ack,
          // count or round-robin update.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        sel_d        = 1'b0;
        last_grant_d = 1'b1;
        count_d      = CNT_ZERO;
      end
    endcase
  end

  // State, select, round-robin pointer and transfer counter registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;   // channel 0 wins the first contention
      count_q      <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  // Outputs: sel/enable/count come straight from flops; acks are the
  // combinational transfer strobe steered by the frozen select.
  always_comb begin
    bus.sel       = sel_q;
    bus.enable    = busy_s;
    bus.xferCount = count_q;
    bus.ack_0     = xfer_s && !sel_q;
    bus.ack_1     = xfer_s && sel_q;
  end

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//   Directed bench for mux2_rr_arbiter. One DUT with cntBits=8 and a second
//   with cntBits=2 for counter wrap. Inputs change 1 time unit after the
//   rising edge; outputs are sampled in the same window.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  logic clock;
  logic resetN;

  int errors = 0;
  int checks = 0;

  mux2_rr_arbiter_if #(.cntBits(8)) bus  ();
  mux2_rr_arbiter_if #(.cntBits(2)) bus2 ();

  mux2_rr_arbiter #(.cntBits(8)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus.master)
  );

  mux2_rr_arbiter #(.cntBits(2)) dut2 (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus2.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_0     = 1'b0;
    bus.req_1     = 1'b0;
    bus.outReady  = 1'b0;
    bus2.req_0    = 1'b0;
    bus2.req_1    = 1'b0;
    bus2.outReady = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    logic [1:0] exp2;
    clear_inputs();
    resetN = 1'b1;

    // ---------------- Reset values (asynchronous, before any edge) --------
    #2;
    resetN = 1'b0;
    #1;
    check("rst_enable", bus.enable, 1'b0);
    check("rst_sel",    bus.sel,    1'b0);
    check("rst_count",  bus.xferCount, 8'd0);
    check("rst_ack",    {bus.ack_1, bus.ack_0}, 2'b00);
    @(posedge clock);
    #1;
    resetN = 1'b1;

    // ---------------- Test 1: single request on channel 0 ----------------
    bus.req_0 = 1'b1;
    tick();
    check("t1_enable", bus.enable, 1'b1);
    check("t1_sel",    bus.sel,    1'b0);
    bus.outReady = 1'b1;
    #1;
    check("t1_ack0", bus.ack_0, 1'b1);
    check("t1_ack1", bus.ack_1, 1'b0);
    tick();
    bus.req_0 = 1'b0;
    #1;
    check("t1_idle",  bus.enable, 1'b0);
    check("t1_ack0_off", bus.ack_0, 1'b0);
    check("t1_count", bus.xferCount, 8'd1);

    // ---------------- Test 2: both requesters continuously ---------------
    do_reset();
    bus.req_0    = 1'b1;
    bus.req_1    = 1'b1;
    bus.outReady = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_enable", bus.enable, 1'b1);
      check("t2_sel",    bus.sel,    i % 2);
      check("t2_ack0",   bus.ack_0,  (i % 2 == 0) ? 1 : 0);
      check("t2_ack1",   bus.ack_1,  (i % 2 == 1) ? 1 : 0);
      check("t2_count",  bus.xferCount, i);
      tick();
    end
    check("t2_count4", bus.xferCount, 8'd4);
    check("t2_no_bubble", bus.enable, 1'b1);

    // ---------------- Test 3: channel 1 alone, three transfers -----------
    do_reset();
    bus.req_1    = 1'b1;
    bus.outReady = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t3_busy",  bus.enable, 1'b1);
      check("t3_sel_b", bus.sel,    1'b1);
      check("t3_ack1",  bus.ack_1,  1'b1);
      tick();
      check("t3_idle",  bus.enable, 1'b0);
      check("t3_sel_i", bus.sel,    1'b1);
      check("t3_ack1_off", bus.ack_1, 1'b0);
      check("t3_count", bus.xferCount, k + 1);
      if (k == 2) begin
        bus.req_1 = 1'b0;
      end
      tick();
    end
    check("t3_final_idle", bus.enable, 1'b0);
    check("t3_final_cnt",  bus.xferCount, 8'd3);

    // ---------------- Test 4: consumer stalls five cycles ----------------
    do_reset();
    bus.req_0 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_en",  bus.enable, 1'b1);
      check("t4_hold_sel", bus.sel,    1'b0);
      check("t4_no_ack",   {bus.ack_1, bus.ack_0}, 2'b00);
      tick();
    end
    bus.outReady = 1'b1;
    #1;
    check("t4_ack0_c6", bus.ack_0, 1'b1);
    tick();
    bus.req_0    = 1'b0;
    bus.outReady = 1'b0;
    check("t4_idle",  bus.enable, 1'b0);
    check("t4_count", bus.xferCount, 8'd1);

    // ---------------- Test 5: abandoned request --------------------------
    do_reset();
    bus.req_1 = 1'b1;
    tick();
    check("t5_busy", bus.enable, 1'b1);
    check("t5_sel1", bus.sel,    1'b1);
    bus.req_1 = 1'b0;
    #1;
    check("t5_no_ack", {bus.ack_1, bus.ack_0}, 2'b00);
    tick();
    check("t5_idle",  bus.enable, 1'b0);
    check("t5_count", bus.xferCount, 8'd0);
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    tick();
    check("t5_cont_en",  bus.enable, 1'b1);
    check("t5_cont_sel", bus.sel,    1'b0);

    // Abandon must leave the round-robin pointer alone after a real grant.
    do_reset();
    bus.req_0    = 1'b1;
    bus.outReady = 1'b1;
    tick();
    tick();
    bus.req_0    = 1'b0;
    bus.outReady = 1'b0;
    bus.req_1    = 1'b1;
    check("t5b_count", bus.xferCount, 8'd1);
    tick();
    check("t5b_sel1", bus.sel, 1'b1);
    bus.req_1 = 1'b0;
    tick();
    check("t5b_idle",  bus.enable, 1'b0);
    check("t5b_count2", bus.xferCount, 8'd1);
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    tick();
    check("t5b_cont_sel", bus.sel, 1'b1);

    // ---------------- Test 6: 2-bit counter wrap and async reset ---------
    do_reset();
    bus2.req_1    = 1'b1;
    bus2.outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_busy", bus2.enable, 1'b1);
      tick();
      exp2 = 2'(k + 1);
      check("t6_idle",  bus2.enable, 1'b0);
      check("t6_count", bus2.xferCount, exp2);
    end
    tick();
    check("t6_pre_en",  bus2.enable, 1'b1);
    check("t6_pre_sel", bus2.sel,    1'b1);
    resetN = 1'b0;
    #1;
    check("t6_rst_en",    bus2.enable,    1'b0);
    check("t6_rst_sel",   bus2.sel,       1'b0);
    check("t6_rst_count", bus2.xferCount, 2'd0);
    check("t6_rst_ack",   bus2.ack_1,     1'b0);
    clear_inputs();
    @(posedge clock);
    #1;
    resetN = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux2_rr_arbiter
